// File: rtl/pqc_pkg.sv
// Shared constants, types and helpers for the polynomial-arithmetic datapath.
package pqc_pkg;

   localparam int unsigned COEFF_WIDTH = 16;
   localparam int unsigned KYBER_Q     = 3329;

   typedef logic [COEFF_WIDTH-1:0]   coeff_t;
   typedef logic [2*COEFF_WIDTH-1:0] prod_t;

   // Barrett constant floor(2**k / q), evaluated at elaboration time.
   function automatic logic [63:0] barrett_m(input logic [63:0] q, input int unsigned k);
      return (64'd1 << k) / q;
   endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// Single conditional modular correction: y = (r >= Q) ? r - Q : r.
module mod_cond_sub
   import pqc_pkg::*;
#(
   parameter int unsigned W = COEFF_WIDTH + 2,
   parameter int unsigned Q = KYBER_Q
) (
   input  logic [W-1:0] r,
   output logic [W-1:0] y
);

   localparam logic [W-1:0] QW = W'(Q);

   assign y = (r >= QW) ? (r - QW) : r;

endmodule

// File: rtl/barrett_reduce.sv
// Three-stage pipelined Barrett reducer: x mod Q for a 2*WIDTH-bit unsigned product.
module barrett_reduce
   import pqc_pkg::*;
#(
   parameter int unsigned WIDTH = COEFF_WIDTH,
   parameter int unsigned Q     = KYBER_Q
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   localparam int unsigned K   = 2 * WIDTH;
   localparam logic [63:0] M   = barrett_m(64'(Q), K);
   localparam int unsigned MW  = $clog2(M + 64'd1);
   localparam int unsigned PW  = K + MW;
   localparam int unsigned RW  = WIDTH + 2;
   localparam logic [MW-1:0]    MC = M[MW-1:0];
   localparam logic [WIDTH-1:0] QC = WIDTH'(Q);

   logic          ce;
   logic          v1;
   logic          v2;
   logic [PW-1:0] p;
   logic [K-1:0]  x1;
   logic [RW-1:0] r2;

   logic [MW-1:0] t;
   logic [K-1:0]  tq;
   logic [K-1:0]  diff;
   logic [RW-1:0] r3a;
   logic [RW-1:0] r3b;
   logic          unused_bits;

   // Every stage advances together, bubbles included, unless the output is stalled.
   assign ce       = !out_valid || out_ready;
   assign in_ready = ce && !rst;

   // t*Q never exceeds x1, so the K-bit difference cannot wrap and fits in RW bits.
   assign t    = p[PW-1:K];
   assign tq   = K'(t) * K'(QC);
   assign diff = x1 - tq;

   assign unused_bits = ^{p[K-1:0], diff[K-1:RW], r3b[RW-1:WIDTH]};

   mod_cond_sub #(.W(RW), .Q(Q)) u_sub0 (
      .r (r2),
      .y (r3a)
   );

   mod_cond_sub #(.W(RW), .Q(Q)) u_sub1 (
      .r (r3a),
      .y (r3b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         p         <= '0;
         x1        <= '0;
         v1        <= 1'b0;
         r2        <= '0;
         v2        <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (ce) begin
         p         <= PW'(in_data) * PW'(MC);
         x1        <= in_data;
         v1        <= in_valid;
         r2        <= diff[RW-1:0];
         v2        <= v1;
         out_data  <= r3b[WIDTH-1:0];
         out_valid <= v2;
      end
   end

endmodule

// File: tb/tb_barrett_reduce.sv
// Scoreboard bench for barrett_reduce: table vectors, stall, mid-stream reset and random sweep.
module tb_barrett_reduce;
   import pqc_pkg::*;

   localparam int unsigned QM = 3329;

   typedef struct {
      logic [31:0] x;
      logic [15:0] e;
   } vec_t;

   typedef struct {
      logic [15:0] e;
      int          c;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   coeff_t      out_data;

   logic [15:0] cur_exp;
   logic        lat_check;
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   sb_t         sb[$];
   vec_t        vecs[6];

   barrett_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reportFail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s (t=%0t)", name, $time);
   endtask

   // Transfers are judged at the falling edge, where both handshakes are stable.
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               reportFail("spurious_output");
            end else begin
               e = sb.pop_front();
               checkOutput("data", out_data, e.e);
               checkOutput("range", out_data < 16'(QM), 1);
               if (lat_check) checkOutput("latency", cyc - e.c, 3);
            end
         end
         if (in_valid && in_ready) sb.push_back('{cur_exp, cyc});
      end
   end

   task automatic applyStimulus(input logic [31:0] x, input logic [15:0] e);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = x;
      cur_exp  = e;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) reportFail("accept_timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int n = 0; n < 100; n++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) reportFail("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] x;
      logic [15:0] held;

      vecs[0] = '{32'd0,          16'd0};
      vecs[1] = '{32'd3329,       16'd0};
      vecs[2] = '{32'd1,          16'd1};
      vecs[3] = '{32'd11075584,   16'd1};
      vecs[4] = '{32'hFFFF_FFFF,  16'd1352};
      vecs[5] = '{32'h0001_0000,  16'd2285};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cur_exp   = '0;
      lat_check = 1'b0;

      // Reset held for two edges.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("rst_out_valid", out_valid, 0);
         checkOutput("rst_out_data", out_data, 0);
         checkOutput("rst_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // Back-to-back table vectors with fixed latency.
      lat_check = 1'b1;
      foreach (vecs[i]) applyStimulus(vecs[i].x, vecs[i].e);
      waitDrain();
      lat_check = 1'b0;

      // Eight operands with a four-cycle output stall in the middle.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               x = 32'(i) * 32'd536870909 + 32'd12345;
               applyStimulus(x, 16'(x % QM));
            end
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            held = out_data;
            for (int k = 0; k < 4; k++) begin
               if (k > 0) @(negedge clk);
               checkOutput("stall_out_valid", out_valid, 1);
               checkOutput("stall_in_ready", in_ready, 0);
               checkOutput("stall_hold", out_data, held);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      waitDrain();

      // Reset with three operands in flight.
      for (int i = 0; i < 3; i++) begin
         x = 32'hDEAD_0000 + 32'(i * 7919);
         applyStimulus(x, 16'(x % QM));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("post_rst_out_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      applyStimulus(32'd6658, 16'd0);
      waitDrain();

      // Random sweep with random handshakes on both sides.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         cur_exp   = 16'(in_data % QM);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/barrett_reduce.md
# barrett_reduce

Pipelined Barrett modular reducer that consumes the `2*WIDTH`-bit product from the `multiply` stage and returns `x mod Q` as a `WIDTH`-bit coefficient. It sits directly downstream of `multiply` in the polynomial-arithmetic datapath and feeds the NTT/accumulate stages. It accepts one operand per cycle behind a valid/ready handshake, with fixed 3-cycle latency when not stalled.

## Interface
- `WIDTH`, 16: coefficient width. Input is `2*WIDTH` bits; requires `Q < 2**WIDTH`.
- `Q`, 3329: modulus (Kyber).
- `K`, `2*WIDTH`: Barrett shift. Derived localparam; not overridden.
- `M`, `floor(2**K / Q)`: Barrett constant. Derived localparam; equals 1290167 for the defaults.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block accepts `in_data` this cycle.
- `in_data`  in  `2*WIDTH`: unsigned operand `x`, typically `multiply.out`.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts `out_data`.
- `out_data`  out  `WIDTH`: `x mod Q`, always in `[0, Q)`.

## Operation
- Global advance enable: `ce = !out_valid || out_ready`.
- `in_ready = ce && !rst`.
- Input transfer occurs when `in_valid && in_ready`.
- Pipeline registers, each with a valid bit `v1`, `v2`, `out_valid`; all update only when `ce`:
  - S1: `p <= x * M` (`K + clog2(M)` bits, 53 for defaults); `x1 <= x`; `v1 <= in_valid`.
  - S2: `t = p >> K`; `r2 <= x1 - t*Q` (`t*Q <= x1`, so there is no underflow; `r2 < 3Q`, width `WIDTH+2`); `v2 <= v1`.
  - S3: apply the conditional subtraction up to twice: `if (r >= Q) r -= Q` twice. Then `out_data <= r[WIDTH-1:0]`; `out_valid <= v2`.
- Bubbles are not collapsed. When `ce` is high, every stage shifts, including invalid slots.
- All arithmetic is unsigned. There is no signed input support; signed lift belongs upstream.

## Timing
- Reset (`rst` high at an edge): `v1`, `v2`, and `out_valid` clear to 0; `out_data`, `p`, `x1`, and `r2` clear to 0. `in_ready` is 0 while `rst` is high.
- Reset mid-operation discards all in-flight data with no output. The first acceptance is possible in the cycle after `rst` deasserts.
- Latency is 3 cycles. An operand accepted at edge N appears with `out_valid = 1` after edge N+2 and is presented during cycle N+3, provided no stall occurs.
- Throughput is 1 result/cycle while `out_ready` stays high.
- Stall: `out_valid && !out_ready` forces `ce = 0`. All stages then hold, `in_ready = 0`, and `out_data` stays stable until the transfer completes.
- Simultaneous events: when `out_ready` rises with `in_valid` high, output transfer and input acceptance happen on the same edge.
- `out_valid` never drops without a transfer, except on reset.

## Structure
- Shared package `pqc_pkg` holds:
  - `Q` and `WIDTH` defaults.
  - Function `barrett_m(q, k)`.
  - Typedefs `coeff_t` (`WIDTH`) and `prod_t` (`2*WIDTH`), shared with `multiply`.
- Single module. The two-step correction is factored into the combinational sub-module `mod_cond_sub` (`r >= Q ? r - Q : r`), instantiated twice in S3.
- The multipliers `x*M` and `t*Q` are inferred; no DSP primitives are instantiated.

## Test plan
- Reset and idle: hold `rst` for 2 cycles. Require `out_valid = 0`, `out_data = 0`, and `in_ready = 0` during reset, then `in_ready = 1` after reset.
- Basic values: feed `x = 0`, `3329`, and `1` back-to-back with `out_ready = 1`. Require outputs `0`, `0`, `1` in consecutive cycles, with the first result 3 cycles after acceptance.
- Operand-range values:
  - `x = 3328*3328 = 11075584` gives `1`.
  - `x = 0xFFFFFFFF` gives `1352`.
  - `x = 0x00010000` gives `65536 mod 3329 = 2285`.
- Backpressure: stream 8 operands and drop `out_ready` for 4 cycles mid-stream. Require `out_data` to be held and `in_ready = 0` during the stall, with no loss or duplication, in order.
- Reset mid-stream: assert `rst` with 3 operands in flight. Require no `out_valid` afterwards until new input is accepted.
- Random sweep: 10k random `x` in `[0, 2**32)` with random `in_valid`/`out_ready`. Scoreboard against `x % Q`, and check `out_data < Q` always.
